// File: rtl/ee354_pb_conditioner_if.sv
// Button-side bundle of the push-button conditioner: the raw button in and
// the four qualified enables out.
interface ee354_pb_conditioner_if;
  logic PB;
  logic DPB;
  logic SCEN;
  logic MCEN;
  logic CCEN;

  modport master (output PB, input DPB, SCEN, MCEN, CCEN);
  modport slave  (input PB, output DPB, SCEN, MCEN, CCEN);
endinterface

// File: rtl/ee354_pb_conditioner.sv
// Push-button conditioner: two-flop synchronizer, debounce of press and release,
// then single-pulse, auto-repeat and continuous enables decoded from the FSM state.
module ee354_pb_conditioner #(
  parameter int N_dc = 28
) (
  input  logic                  CLK,
  input  logic                  RESET,
  ee354_pb_conditioner_if.slave pb_bus
);

  // Terminal counts D-1, H-1, R-1 built as bit patterns so they are exactly N_dc wide.
  localparam logic [N_dc-1:0] D_LAST  = {{6{1'b0}}, {(N_dc-6){1'b1}}};
  localparam logic [N_dc-1:0] H_LAST  = {{3{1'b0}}, {(N_dc-3){1'b1}}};
  localparam logic [N_dc-1:0] R_LAST  = {{4{1'b0}}, {(N_dc-4){1'b1}}};
  localparam logic [N_dc-1:0] CNT_ONE = {{(N_dc-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    INI     = 3'd0,
    WQ      = 3'd1,
    SCEN_ST = 3'd2,
    WH      = 3'd3,
    MCEN_ST = 3'd4,
    CCR     = 3'd5,
    WFCR    = 3'd6
  } state_t;

  state_t          state_reg, state_next;
  logic [N_dc-1:0] cnt_reg, cnt_next;
  logic            pb_s1_reg, pb_s2_reg;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= INI;
      cnt_reg   <= '0;
      pb_s1_reg <= 1'b0;
      pb_s2_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pb_s1_reg <= pb_bus.PB;
      pb_s2_reg <= pb_s1_reg;
    end
  end

  // A low synchronized button is tested before the terminal count so a drop always wins.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      INI: begin
        cnt_next = '0;
        if (pb_s2_reg) state_next = WQ;
      end
      WQ: begin
        if (!pb_s2_reg) begin
          state_next = INI;
          cnt_next   = '0;
        end else if (cnt_reg == D_LAST) begin
          state_next = SCEN_ST;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      SCEN_ST: begin
        state_next = WH;
        cnt_next   = '0;
      end
      WH: begin
        if (!pb_s2_reg) begin
          state_next = WFCR;
          cnt_next   = '0;
        end else if (cnt_reg == H_LAST) begin
          state_next = MCEN_ST;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      MCEN_ST: begin
        state_next = CCR;
        cnt_next   = '0;
      end
      CCR: begin
        if (!pb_s2_reg) begin
          state_next = WFCR;
          cnt_next   = '0;
        end else if (cnt_reg == R_LAST) begin
          state_next = MCEN_ST;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      WFCR: begin
        // A bounce high restarts the release window without leaving the state.
        if (pb_s2_reg) begin
          cnt_next = '0;
        end else if (cnt_reg == D_LAST) begin
          state_next = INI;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = INI;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    pb_bus.DPB  = (state_reg != INI) && (state_reg != WQ);
    pb_bus.SCEN = (state_reg == SCEN_ST);
    pb_bus.MCEN = (state_reg == SCEN_ST) || (state_reg == MCEN_ST);
    pb_bus.CCEN = (state_reg == SCEN_ST) || (state_reg == MCEN_ST) || (state_reg == CCR);
  end

endmodule

// File: tb/tb_ee354_pb_conditioner.sv
// Bench for ee354_pb_conditioner at N_dc=10 (D=16, H=128, R=64): directed and random
// button waveforms, expected outputs queued per edge and checked by a separate monitor.
module tb_ee354_pb_conditioner;

  localparam int N_DC = 10;
  localparam int D    = 2 ** (N_DC - 6);
  localparam int H    = 2 ** (N_DC - 3);
  localparam int R    = 2 ** (N_DC - 4);

  logic CLK = 1'b0;
  logic RESET;
  ee354_pb_conditioner_if bus ();

  ee354_pb_conditioner #(.N_dc(N_DC)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .pb_bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  int compared   = 0;
  int mismatched = 0;
  int cycle      = 0;
  logic [3:0] exp_q[$];

  // Reference: press = D+1 consecutive high samples of the synchronized button;
  // while held, time t since the press gives pulses at t=0 and t=H+1+k*(R+1);
  // release needs D consecutive low samples after the first low seen outside a pulse.
  int   m_phase = 0;
  int   m_run   = 0;
  int   m_t     = 0;
  int   m_zl    = 0;
  logic m_s1    = 1'b0;
  logic m_s2    = 1'b0;

  function automatic logic is_pulse(input int t);
    return (t == 0) || ((t >= H + 1) && (((t - H - 1) % (R + 1)) == 0));
  endfunction

  always @(posedge CLK) begin
    logic       x;
    logic [3:0] e;
    cycle = cycle + 1;
    if (RESET) begin
      m_s1 = 1'b0; m_s2 = 1'b0;
      m_phase = 0; m_run = 0; m_t = 0; m_zl = 0;
    end else begin
      x    = m_s2;
      m_s2 = m_s1;
      m_s1 = bus.PB;
      case (m_phase)
        0: begin
          if (x) begin
            m_run = m_run + 1;
            if (m_run == D + 1) begin
              m_phase = 1; m_t = 0; m_run = 0;
            end
          end else begin
            m_run = 0;
          end
        end
        1: begin
          if (!is_pulse(m_t) && !x) begin
            m_phase = 2; m_zl = D;
          end else begin
            m_t = m_t + 1;
          end
        end
        default: begin
          if (x) m_zl = D;
          else begin
            m_zl = m_zl - 1;
            if (m_zl == 0) begin
              m_phase = 0; m_run = 0;
            end
          end
        end
      endcase
    end
    if (m_phase == 0)      e = 4'b0000;
    else if (m_phase == 2) e = 4'b1000;
    else e = {1'b1, (m_t == 0), is_pulse(m_t), (m_t == 0) || (m_t >= H + 1)};
    exp_q.push_back(e);
  end

  logic [3:0] prev_act = 4'b0000;

  always @(negedge CLK) begin
    logic [3:0] act;
    logic [3:0] e;
    act = {bus.DPB, bus.SCEN, bus.MCEN, bus.CCEN};
    compared = compared + 1;
    if (exp_q.size() == 0) begin
      mismatched = mismatched + 1;
      $display("FAIL queue_empty cycle=%0d actual=%b required=an expected entry", cycle, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        mismatched = mismatched + 1;
        $display("FAIL outputs cycle=%0d actual DPB/SCEN/MCEN/CCEN=%b required=%b", cycle, act, e);
      end
    end
    if (act !== prev_act)
      $display("cycle=%0d RESET=%b PB=%b DPB=%b SCEN=%b MCEN=%b CCEN=%b",
               cycle, RESET, bus.PB, act[3], act[2], act[1], act[0]);
    prev_act = act;
  end

  // Called right after a falling edge; PB is held for n cycles.
  task automatic hold(input logic pb, input int n);
    bus.PB = pb;
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    int r;
    int len;
    RESET  = 1'b1;
    bus.PB = 1'b1;
    @(negedge CLK);
    hold(1'b1, 2);
    RESET = 1'b0;
    hold(1'b1, 40);
    hold(1'b0, 40);

    // clean short press
    hold(1'b1, 40);
    hold(1'b0, 40);

    // bouncy press, then a stable press
    for (int i = 0; i < 12; i++) hold((i % 2) == 0, 5);
    hold(1'b1, 40);
    hold(1'b0, 40);

    // long hold with auto-repeat
    hold(1'b1, 400);
    hold(1'b0, 40);

    // release bounce: 3-cycle glitch inside the release window
    hold(1'b1, 40);
    hold(1'b0, 8);
    hold(1'b1, 3);
    hold(1'b0, 40);

    // reset mid-hold, button stays pressed
    hold(1'b1, 170);
    RESET = 1'b1;
    hold(1'b1, 2);
    RESET = 1'b0;
    hold(1'b1, 60);
    hold(1'b0, 40);

    // random segments, occasional long holds and resets
    for (int s = 0; s < 40; s++) begin
      r = $urandom_range(0, 9);
      if (r < 5)      len = $urandom_range(1, 20);
      else if (r < 8) len = $urandom_range(15, 60);
      else            len = $urandom_range(120, 300);
      if ($urandom_range(0, 9) == 0) begin
        RESET = 1'b1;
        hold(bus.PB, $urandom_range(1, 3));
        RESET = 1'b0;
      end
      hold(logic'($urandom_range(0, 1)), len);
    end
    hold(1'b0, 40);

    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ee354_pb_conditioner.md
# ee354_pb_conditioner

Push-button conditioning stage that sits between a raw board button (BtnL/BtnU/BtnR/BtnD) and the core logic of a lab top. It synchronizes the asynchronous button and debounces press and release. It then produces four qualified signals: a debounced level, a single-clock press pulse, auto-repeat pulses while the button is held, and a continuous enable while held. The top feeds SCEN to Start/Ack, the A/B capture logic, or single-step CEN inputs.

## Interface
- N_dc, default 28: counter width. Derived windows:
  - debounce D = 2^(N_dc-6) cycles (2^22 ≈ 42 ms at 100 MHz)
  - hold H = 2^(N_dc-3) cycles
  - repeat R = 2^(N_dc-4) cycles
  - Minimum legal N_dc is 8.
- CLK  in  1  system clock (100 MHz on board).
- RESET  in  1  reset; synchronous and active-high.
- PB  in  1  raw push-button, asynchronous, bouncy.
- DPB  out  1  debounced level.
- SCEN  out  1  single-clock enable pulse, once per debounced press.
- MCEN  out  1  multiple-clock enable: one pulse at press, then repeat pulses while held.
- CCEN  out  1  continuous-clock enable: high every cycle while held past the hold window.

## Operation
- Synchronizer: two flops, PB → PB_s1 → PB_s2. Only PB_s2 is used by the FSM.
- One N_dc-bit counter CNT. It is cleared on every state change unless stated otherwise.
- FSM states and transitions:
  - INI: if PB_s2=1 → WQ.
  - WQ: if PB_s2=0 → INI. Otherwise CNT++. If CNT==D-1 → SCEN_ST.
  - SCEN_ST: one cycle, unconditional → WH.
  - WH: if PB_s2=0 → WFCR. Otherwise CNT++. If CNT==H-1 → MCEN_ST.
  - MCEN_ST: one cycle, unconditional → CCR.
  - CCR: if PB_s2=0 → WFCR. Otherwise CNT++. If CNT==R-1 → MCEN_ST.
  - WFCR: if PB_s2=1, clear CNT and stay. Otherwise CNT++. If CNT==D-1 → INI.
- Outputs are Moore, decoded from the state register only:
  - DPB=1 in every state except INI and WQ.
  - SCEN=1 only in SCEN_ST.
  - MCEN=1 in SCEN_ST and MCEN_ST.
  - CCEN=1 in SCEN_ST, MCEN_ST and CCR.
- Bounce during WQ returns to INI and CNT restarts. Bounce during WFCR restarts the release window; DPB stays 1.
- A press released before H cycles produces exactly one SCEN and one MCEN, and no further pulses.
- Simultaneous PB_s2 drop and CNT terminal count in WQ, WH or CCR: the drop wins (→ INI, WFCR, WFCR respectively).
- CNT never wraps. Every terminal compare is below 2^N_dc.

## Timing
- Reset: on the first CLK edge with RESET=1:
  - state=INI, CNT=0, PB_s1=PB_s2=0
  - DPB=SCEN=MCEN=CCEN=0
- Reset mid-hold: outputs drop at the next edge. If PB is still high after RESET falls, a fresh debounce runs and a new SCEN is produced.
- Press latency: let edge k be the first edge that samples PB=1 into PB_s1, with PB stable afterwards.
  - WQ is entered at edge k+2.
  - SCEN_ST is entered at edge k+D+2.
  - SCEN, MCEN and CCEN are high for exactly that one cycle.
- First repeat: MCEN_ST is entered H+1 edges after SCEN_ST. Subsequent MCEN pulses have a period of R+1 cycles.
- Release latency: let edge m be the first edge that samples PB=0 into PB_s1, with PB stable low afterwards.
  - WFCR is entered at edge m+2.
  - DPB falls at edge m+D+2.
- A new press is not recognized until INI is reached.

## Test plan
Benches use N_dc=10, giving D=16, H=128, R=64.
- Reset: hold RESET 3 cycles with PB=1 → all outputs 0 during reset. After release, SCEN pulses once at the 18th edge after the first sampling edge.
- Clean short press: PB high 40 cycles → SCEN, MCEN and CCEN each high exactly 1 cycle at the same edge. DPB rises with them and falls 18 edges after PB is first sampled low. No other pulses occur.
- Bouncy press: PB toggles every 5 cycles for 60 cycles, then stays high 40 cycles → zero pulses during bouncing. Exactly one SCEN occurs 18 edges after the final rise is sampled.
- Long hold: PB high 400 cycles →
  - SCEN at t0
  - MCEN at t0, t0+129, t0+194 and t0+259, then every 65 cycles while held
  - CCEN continuously high from t0+129 until release reaches WFCR
- Release bounce: after a short press, PB low with a single 3-cycle high glitch mid-window → DPB stays 1. DPB falls 18 edges after the last sampled low-going edge. No new SCEN.
- Reset mid-hold: assert RESET at t0+150 while PB stays high → outputs 0 at the next edge. Exactly one new SCEN 18 edges after reset releases.
